// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary conversion path.
// Holds the FSM state encoding and the largest legal BCD digit value.
package bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } conv_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: digits of 8 or more lose 3.
// Plain 4-bit subtract, so invalid digits (10..15) wrap harmlessly to 7..12.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_bin_conv.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift step per clock.
// The result is produced in the lower half of the shift register after BIN_W steps.
module bcd_to_bin_conv
    import bcd_pkg::*;
#(
    parameter  int NDIGITS = 2,
    localparam int BIN_W   = 4 * NDIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bcd,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] bin
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    conv_state_e        state;
    logic [CNT_W-1:0]   cnt;
    logic [2*BIN_W-1:0] sr;
    logic [2*BIN_W-1:0] shifted;
    logic [BIN_W-1:0]   adj_hi;
    logic [2*BIN_W-1:0] next_sr;
    logic               bad_digit;

    assign shifted = sr >> 1;

    // Each upper-half digit is corrected independently; there is no carry between digits.
    for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (shifted[BIN_W + 4*g +: 4]),
            .dout (adj_hi[4*g +: 4])
        );
    end

    assign next_sr = {adj_hi, shifted[BIN_W-1:0]};

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd[4*i +: 4] > BCD_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    // The final step loads bin straight from next_sr, so the result lands on the same edge as done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            bin   <= '0;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sr    <= {bcd, {BIN_W{1'b0}}};
                        cnt   <= '0;
                        err   <= bad_digit;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sr  <= next_sr;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        bin   <= err ? '0 : next_sr[BIN_W-1:0];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// Directed self-checking bench for bcd_to_bin_conv with a 2-digit and a 3-digit instance.
// Expected values are hand-computed decimal equivalents of the BCD inputs.
module tb_bcd_to_bin_conv;

    logic        clk = 1'b0;
    logic        rst;

    logic        start2;
    logic [7:0]  bcd2;
    logic        busy2, done2, err2;
    logic [7:0]  bin2;

    logic        start3;
    logic [11:0] bcd3;
    logic        busy3, done3, err3;
    logic [11:0] bin3;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    bcd_to_bin_conv #(.NDIGITS(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .bcd   (bcd2),
        .busy  (busy2),
        .done  (done2),
        .err   (err2),
        .bin   (bin2)
    );

    bcd_to_bin_conv #(.NDIGITS(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .start (start3),
        .bcd   (bcd3),
        .busy  (busy3),
        .done  (done3),
        .err   (err3),
        .bin   (bin3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion on the selected instance, checking busy, latency, result and pulse width.
    task automatic applyStimulus(input int which, input logic [11:0] v, input int expBin,
                                 input logic expErr, input string tag);
        int   n;
        logic d;
        if (which == 2) begin
            bcd2   = v[7:0];
            start2 = 1'b1;
        end else begin
            bcd3   = v;
            start3 = 1'b1;
        end
        tick();
        start2 = 1'b0;
        start3 = 1'b0;
        checkOutput({tag, " busy"}, (which == 2) ? busy2 : busy3, 1);
        n = 0;
        d = (which == 2) ? done2 : done3;
        while (!d && n < 40) begin
            tick();
            n++;
            d = (which == 2) ? done2 : done3;
        end
        checkOutput({tag, " latency"}, n, (which == 2) ? 8 : 12);
        checkOutput({tag, " bin"}, (which == 2) ? {4'd0, bin2} : bin3, expBin);
        checkOutput({tag, " err"}, (which == 2) ? err2 : err3, {31'd0, expErr});
        tick();
        checkOutput({tag, " done width"}, (which == 2) ? done2 : done3, 0);
        checkOutput({tag, " idle"}, (which == 2) ? busy2 : busy3, 0);
    endtask

    initial begin
        int n;
        int dones;
        logic [7:0] gotBin;

        rst    = 1'b1;
        start2 = 1'b1;
        bcd2   = 8'h42;
        start3 = 1'b0;
        bcd3   = 12'h000;
        tick();
        tick();
        checkOutput("reset busy", busy2, 0);
        checkOutput("reset done", done2, 0);
        checkOutput("reset err", err2, 0);
        checkOutput("reset bin", bin2, 0);
        checkOutput("reset busy3", busy3, 0);
        rst    = 1'b0;
        start2 = 1'b0;
        tick();

        applyStimulus(2, 12'h042, 42, 1'b0, "bcd42");
        applyStimulus(2, 12'h099, 99, 1'b0, "bcd99");
        applyStimulus(2, 12'h000, 0, 1'b0, "bcd00");
        applyStimulus(2, 12'h059, 59, 1'b0, "bcd59");

        applyStimulus(2, 12'h03A, 0, 1'b1, "bcd3A");
        tick();
        checkOutput("err held", err2, 1);
        applyStimulus(2, 12'h015, 15, 1'b0, "bcd15");

        // Second start in mid-conversion must be dropped entirely.
        bcd2   = 8'h27;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        tick();
        tick();
        bcd2   = 8'h63;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        bcd2   = 8'h00;
        dones  = 0;
        gotBin = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (done2) begin
                dones++;
                gotBin = bin2;
            end
        end
        checkOutput("ignore start dones", dones, 1);
        checkOutput("ignore start bin", gotBin, 27);
        checkOutput("ignore start idle", busy2, 0);

        // Reset in flight discards the conversion and clears held outputs.
        bcd2   = 8'hA1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        checkOutput("abort err set", err2, 1);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("abort busy", busy2, 0);
        checkOutput("abort done", done2, 0);
        checkOutput("abort err", err2, 0);
        checkOutput("abort bin", bin2, 0);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done2) dones++;
        end
        checkOutput("abort no done", dones, 0);
        applyStimulus(2, 12'h056, 56, 1'b0, "after abort");

        applyStimulus(3, 12'h999, 999, 1'b0, "bcd999");
        applyStimulus(3, 12'h305, 305, 1'b0, "bcd305");

        // Start held high: accepts should repeat every BIN_W+2 cycles.
        bcd3   = 12'h999;
        start3 = 1'b1;
        n = 0;
        while (!done3 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("b2b first done", done3, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done3 && n < 40);
        start3 = 1'b0;
        checkOutput("b2b period", n, 14);
        checkOutput("b2b bin", bin3, 999);
        tick();
        tick();
        checkOutput("b2b idle", busy3, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
